// File: rtl/rx_mf_decim_slicer_if.sv
// Sample-rate input stream and symbol-rate decision stream of the receive matched filter.
interface rx_mf_decim_slicer_if;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic signed [17:0] x_in;
    logic signed [17:0] y_sym;
    logic [1:0]         sym_out;
    logic               y_valid;
    logic               busy;
    logic               err_overrun;

    modport master (
        output sam_clk_en, sym_clk_en, x_in,
        input  y_sym, sym_out, y_valid, busy, err_overrun
    );
    modport slave (
        input  sam_clk_en, sym_clk_en, x_in,
        output y_sym, sym_out, y_valid, busy, err_overrun
    );
endinterface

// File: rtl/rx_mf_decim_slicer.sv
// 81-tap folded RRC matched filter decimated to symbol rate, time-shared over MAC lanes,
// followed by a 4-ASK Gray slicer.

module rx_mf_lane #(
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    prod_en,
    input  logic                    acc_en,
    input  logic signed [18:0]      s,
    input  logic signed [17:0]      h,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [36:0] prod;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod <= '0;
            acc  <= '0;
        end else if (clr) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (prod_en) prod <= s * h;
            if (acc_en)  acc  <= acc + {{(ACC_W-37){prod[36]}}, prod};
        end
    end
endmodule

module rx_mf_decim_slicer #(
    parameter int                 NTAPS  = 81,
    parameter int                 NLANES = 3,
    parameter logic signed [17:0] THRESH = 18'sd49152,
    parameter int                 ACC_W  = 40
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rx_mf_decim_slicer_if.slave  bus
);
    localparam int NUNIQ = (NTAPS + 1) / 2;
    localparam int NMAC  = (NUNIQ + NLANES - 1) / NLANES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_SUM  = 2'd2;

    localparam logic signed [ACC_W-1:0] YMAX = 131071;
    localparam logic signed [ACC_W-1:0] YMIN = -131072;

    logic signed [17:0]              dl   [NTAPS];
    logic signed [18:0]              snap [NUNIQ];
    logic [1:0]                      state;
    logic [3:0]                      cnt;
    logic                            prod_en, acc_en;
    logic [NLANES-1:0][ACC_W-1:0]    lane_acc;
    logic signed [ACC_W-1:0]         total, shifted;
    logic signed [17:0]              ysat;
    logic signed [17:0]              y_q;
    logic [1:0]                      sym_q;
    logic                            valid_q, err_q;

    // Receive-RRC half table, h[40] is the centre tap; taps sum to 2^18 (unity DC gain).
    function automatic logic signed [17:0] coef(input logic [5:0] n);
        case (n)
            6'd0:  coef =  18'sd60;     6'd1:  coef =  18'sd20;
            6'd2:  coef = -18'sd50;     6'd3:  coef = -18'sd120;
            6'd4:  coef = -18'sd170;    6'd5:  coef = -18'sd150;
            6'd6:  coef = -18'sd50;     6'd7:  coef =  18'sd100;
            6'd8:  coef =  18'sd250;    6'd9:  coef =  18'sd330;
            6'd10: coef =  18'sd300;    6'd11: coef =  18'sd100;
            6'd12: coef = -18'sd200;    6'd13: coef = -18'sd500;
            6'd14: coef = -18'sd700;    6'd15: coef = -18'sd600;
            6'd16: coef = -18'sd200;    6'd17: coef =  18'sd400;
            6'd18: coef =  18'sd1000;   6'd19: coef =  18'sd1300;
            6'd20: coef =  18'sd1100;   6'd21: coef =  18'sd300;
            6'd22: coef = -18'sd900;    6'd23: coef = -18'sd2000;
            6'd24: coef = -18'sd2500;   6'd25: coef = -18'sd1900;
            6'd26: coef =  18'sd0;      6'd27: coef =  18'sd2600;
            6'd28: coef =  18'sd4700;   6'd29: coef =  18'sd5200;
            6'd30: coef =  18'sd3000;   6'd31: coef = -18'sd1500;
            6'd32: coef = -18'sd7000;   6'd33: coef = -18'sd11500;
            6'd34: coef = -18'sd11000;  6'd35: coef = -18'sd4000;
            6'd36: coef =  18'sd10352;  6'd37: coef =  18'sd22000;
            6'd38: coef =  18'sd38000;  6'd39: coef =  18'sd55000;
            6'd40: coef =  18'sd60000;
            default: coef = '0;
        endcase
    endfunction

    function automatic logic [1:0] slice(input logic signed [17:0] y);
        if (y < -THRESH)     slice = 2'b00;
        else if (y < 0)      slice = 2'b01;
        else if (y < THRESH) slice = 2'b11;
        else                 slice = 2'b10;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) dl[k] <= '0;
        end else if (bus.sam_clk_en) begin
            dl[0] <= bus.x_in;
            for (int k = 1; k < NTAPS; k++) dl[k] <= dl[k-1];
        end
    end

    // Fold the symmetric halves once per symbol so each lane sees one 19-bit operand per tap pair.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUNIQ; k++) snap[k] <= '0;
        end else if (bus.sym_clk_en) begin
            for (int k = 0; k < NUNIQ - 1; k++) snap[k] <= 19'(dl[k]) + 19'(dl[NTAPS-1-k]);
            snap[NUNIQ-1] <= 19'(dl[NUNIQ-1]);
        end
    end

    // Products are registered one clk ahead of accumulation, so cnt runs one past the last MAC.
    assign prod_en = (state == S_MAC) && (cnt < 4'(NMAC));
    assign acc_en  = (state == S_MAC) && (cnt != 4'd0);

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [5:0]         idx;
        logic signed [18:0] s_sel;
        logic signed [17:0] h_sel;

        assign idx = 6'(NMAC * l) + {2'b00, cnt};

        always_comb begin
            s_sel = '0;
            h_sel = '0;
            if (idx < 6'(NUNIQ)) begin
                s_sel = snap[idx];
                h_sel = coef(idx);
            end
        end

        rx_mf_lane #(.ACC_W(ACC_W)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (bus.sym_clk_en),
            .prod_en (prod_en),
            .acc_en  (acc_en),
            .s       (s_sel),
            .h       (h_sel),
            .acc     (lane_acc[l])
        );
    end

    always_comb begin
        total = '0;
        for (int l = 0; l < NLANES; l++) total = total + $signed(lane_acc[l]);
        shifted = total >>> 18;
        if (shifted > YMAX)      ysat = YMAX[17:0];
        else if (shifted < YMIN) ysat = YMIN[17:0];
        else                     ysat = shifted[17:0];
    end

    // A new symbol strobe always restarts; on the SUM edge the finishing result still goes out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            y_q     <= '0;
            sym_q   <= 2'b11;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state == S_SUM) begin
                y_q     <= ysat;
                sym_q   <= slice(ysat);
                valid_q <= 1'b1;
            end
            if (bus.sym_clk_en) begin
                if (state == S_MAC) err_q <= 1'b1;
                state <= S_MAC;
                cnt   <= '0;
            end else begin
                case (state)
                    S_MAC: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(NMAC)) state <= S_SUM;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.y_sym       = y_q;
    assign bus.sym_out     = sym_q;
    assign bus.y_valid     = valid_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_rx_mf_decim_slicer.sv
// Bench for rx_mf_decim_slicer: direct-form 81-tap reference model feeding a scoreboard,
// with impulse, DC, slicer-boundary, saturation, overrun, reset and random phases.
module tb_rx_mf_decim_slicer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rx_mf_decim_slicer_if bus();

    rx_mf_decim_slicer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         y;
        logic [1:0] s;
    } exp_t;

    exp_t q[$];
    int   htab [41] = '{60, 20, -50, -120, -170, -150, -50, 100, 250, 330, 300, 100,
                        -200, -500, -700, -600, -200, 400, 1000, 1300, 1100, 300,
                        -900, -2000, -2500, -1900, 0, 2600, 4700, 5200, 3000, -1500,
                        -7000, -11500, -11000, -4000, 10352, 22000, 38000, 55000, 60000};
    int   levels [6] = '{-49153, -49152, -1, 0, 49151, 49152};
    int   hist [81];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0, pend = 1'b0;
    bit   exp_valid = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
    int   age = 0, pend_y = 0, exp_y = 0;
    logic [1:0] exp_sym = 2'b11;

    function automatic logic [1:0] slice(input int y);
        if (y < -49152) return 2'b00;
        if (y < 0)      return 2'b01;
        if (y < 49152)  return 2'b11;
        return 2'b10;
    endfunction

    // Full 81-tap convolution over the newest-first sample history, floored and clamped.
    function automatic int mf();
        longint acc = 0;
        for (int k = 0; k < 81; k++)
            acc += longint'(hist[k]) * longint'(htab[k <= 40 ? k : 80 - k]);
        acc = acc >>> 18;
        if (acc > 131071)       acc = 131071;
        else if (acc < -131072) acc = -131072;
        return int'(acc);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a result is due 16 edges after its strobe unless a new strobe preempts it.
    always @(posedge clk) begin
        exp_valid = 1'b0;
        if (!reset_n) begin
            foreach (hist[k]) hist[k] = 0;
            pend = 1'b0; age = 0; exp_busy = 1'b0; exp_err = 1'b0;
            exp_y = 0; exp_sym = 2'b11;
            q.delete();
            mon_en = 1'b1;
        end else begin
            if (pend) begin
                age++;
                if (age == 16) begin
                    exp_valid = 1'b1;
                    exp_y     = pend_y;
                    exp_sym   = slice(pend_y);
                    pend      = 1'b0;
                end
            end
            if (bus.sym_clk_en) begin
                if (pend) begin
                    exp_err = 1'b1;
                    q.delete(q.size() - 1);
                end
                pend   = 1'b1;
                age    = 0;
                pend_y = mf();
                q.push_back('{pend_y, slice(pend_y)});
            end
            if (bus.sam_clk_en) begin
                for (int k = 80; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = $signed(bus.x_in);
            end
            exp_busy = pend;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("y_valid", 32'(bus.y_valid), 32'(exp_valid));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("err_overrun", 32'(bus.err_overrun), 32'(exp_err));
            chk("y_sym_hold", 32'($signed(bus.y_sym)), exp_y);
            chk("sym_out_hold", 32'(bus.sym_out), 32'(exp_sym));
            if (bus.y_valid === 1'b1) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_pop: got y_valid with y_sym %0d expected no result at %0t",
                             $signed(bus.y_sym), $time);
                end else begin
                    e = q.pop_front();
                    chk("sb_y_sym", 32'($signed(bus.y_sym)), e.y);
                    chk("sb_sym_out", 32'(bus.sym_out), 32'(e.s));
                end
            end
        end
    end

    task automatic step(input logic sam, input logic sym, input int x, input logic rn);
        bus.sam_clk_en = sam;
        bus.sym_clk_en = sym;
        bus.x_in       = 18'(x);
        reset_n        = rn;
        @(negedge clk);
    endtask

    // mode 0: single impulse of 'level' then zeros; mode 1: constant 'level'.
    task automatic stream(input int ncyc, input int mode, input int level);
        int ns = 0;
        for (int i = 0; i < ncyc; i++) begin
            logic sam;
            int   x;
            sam = (i % 4 == 0);
            x   = 0;
            if (sam) begin
                x = (mode == 0) ? ((ns == 0) ? level : 0) : level;
                ns++;
            end
            step(sam, (i % 16 == 15), x, 1'b1);
        end
    endtask

    initial begin
        int since;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        bus.x_in       = '0;
        @(negedge clk);
        repeat (3) step(0, 0, 0, 0);

        stream(400, 0, 131071);
        stream(24 * 16, 1, 65536);
        foreach (levels[i]) stream(24 * 16, 1, levels[i]);

        for (int sg = 1; sg >= -1; sg -= 2) begin
            for (int j = 80; j >= 0; j--)
                step(1, 0, (htab[j <= 40 ? j : 80 - j] < 0 ? -sg : sg) * 131071, 1);
            step(0, 1, 0, 1);
            repeat (17) step(0, 0, 0, 1);
        end

        step(0, 1, 0, 1);
        repeat (7) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        repeat (24) step(0, 0, 0, 1);

        step(0, 1, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        repeat (18) step(0, 0, 0, 1);

        since = 0;
        for (int i = 0; i < 3000; i++) begin
            logic sam, sym;
            int   x;
            sam   = ($urandom_range(0, 3) == 0);
            sym   = (since >= 15) || ($urandom_range(0, 59) == 0);
            x     = int'($urandom_range(0, 262143)) - 131072;
            since = sym ? 0 : since + 1;
            step(sam, sym, x, 1);
        end

        repeat (20) step(0, 0, 0, 1);
        chk("sb_leftover", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
